// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot/binary grant and release-by-done.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_gnt, w_gnt_d;
  logic [2:0] r_gnt_idx, w_gnt_idx_d;
  logic       r_gnt_valid, w_gnt_valid_d;
  logic       r_timeout, w_timeout_d;
  logic [2:0] r_last_idx, w_last_idx_d;

  logic       w_pick_found;
  logic [2:0] w_pick_idx;
  logic       w_release;
  logic       w_hold_expired;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  // Offset 8 wraps back to last_idx itself, so a lone requester is re-granted.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = r_last_idx;
    for (int unsigned i = 1; i <= 8; i++) begin
      if (!w_pick_found && req[3'(r_last_idx + 3'(i))]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = 3'(r_last_idx + 3'(i));
      end
    end
  end

  assign w_release = done || !req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt, w_hold_cnt_d;

  always_comb begin
    w_hold_cnt_d = '0;
    if (r_state == StBusy) begin
      w_hold_cnt_d = r_hold_cnt + 8'd1;
    end
  end

  // Counter holds (busy cycles - 1); expiry lands on the MAX_HOLD-th busy cycle.
  assign w_hold_expired = (r_hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_cnt_d;
    end
  end
`else
  assign w_hold_expired = 1'b0;
`endif

  always_comb begin
    w_state_d     = r_state;
    w_gnt_idx_d   = r_gnt_idx;
    w_gnt_valid_d = r_gnt_valid;
    w_last_idx_d  = r_last_idx;
    w_timeout_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_found) begin
          w_state_d     = StBusy;
          w_gnt_idx_d   = w_pick_idx;
          w_gnt_valid_d = 1'b1;
        end
      end
      StBusy: begin
        if (w_release || w_hold_expired) begin
          w_state_d     = StIdle;
          w_gnt_valid_d = 1'b0;
          w_last_idx_d  = r_gnt_idx;
          w_timeout_d   = !w_release;
        end
      end
      default: begin
        w_state_d     = StIdle;
        w_gnt_valid_d = 1'b0;
      end
    endcase
    w_gnt_d = w_gnt_valid_d ? (8'd1 << w_gnt_idx_d) : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last_idx  <= 3'd7;
    end else begin
      r_state     <= w_state_d;
      r_gnt       <= w_gnt_d;
      r_gnt_idx   <= w_gnt_idx_d;
      r_gnt_valid <= w_gnt_valid_d;
      r_timeout   <= w_timeout_d;
      r_last_idx  <= w_last_idx_d;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed + random bench for rr_arbiter_8: a reference model queues expected outputs per
// driven cycle, which are popped and checked one edge later. Honours ARB_TIMEOUT_EN.
module tb_rr_arbiter_8;

  localparam int TbMaxHold = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter_8 #(.MAX_HOLD(TbMaxHold)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state
  bit m_valid = 0;
  int m_idx   = 0;
  int m_last  = 7;
  int m_busy  = 0;
  bit m_to    = 0;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    assert (act === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic [7:0] q, input logic d);
    bit rel;
    bit tmo;
    if (!r) begin
      m_valid = 0; m_idx = 0; m_last = 7; m_busy = 0; m_to = 0;
    end else if (!m_valid) begin
      m_to = 0;
      for (int k = 1; k <= 8; k++) begin
        if (!m_valid && q[(m_last + k) % 8]) begin
          m_valid = 1;
          m_idx   = (m_last + k) % 8;
          m_busy  = 1;
        end
      end
    end else begin
      rel = d || !q[m_idx];
`ifdef ARB_TIMEOUT_EN
      tmo = !rel && (m_busy >= TbMaxHold);
`else
      tmo = 0;
`endif
      if (rel || tmo) begin
        m_valid = 0;
        m_last  = m_idx;
        m_to    = tmo;
      end else begin
        m_busy++;
        m_to = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic d, input string tag);
    exp_t e;
    exp_t o;
    rst_n = r;
    req   = q;
    done  = d;
    model(r, q, d);
    e.valid = m_valid;
    e.idx   = 3'(m_idx);
    e.gnt   = m_valid ? (8'd1 << m_idx) : 8'd0;
    e.to    = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk({tag, "_gnt"}, gnt, o.gnt);
    chk({tag, "_idx"}, {5'd0, gnt_idx}, {5'd0, o.idx});
    chk({tag, "_valid"}, {7'd0, gnt_valid}, {7'd0, o.valid});
    chk({tag, "_timeout"}, {7'd0, timeout}, {7'd0, o.to});
    chk({tag, "_onehot"}, {7'd0, $onehot0(gnt)}, 8'd1);
  endtask

  initial begin
    int n_to;
    logic [7:0] rq;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // Reset, requests present during reset must not grant
    step(0, 8'h00, 0, "rst0");
    step(0, 8'h81, 0, "rst1");
    chk("rst_gnt_zero", gnt, 8'h00);

    // Requester 0 wins after reset, then 7 exactly two edges after done
    step(1, 8'h81, 0, "p0_grant");
    chk("p0_is_0", gnt, 8'h01);
    step(1, 8'h81, 0, "p0_hold");
    step(1, 8'h81, 1, "p0_done");
    chk("p0_released", gnt, 8'h00);
    step(1, 8'h81, 0, "p7_grant");
    chk("p7_is_7", gnt, 8'h80);
    step(1, 8'h81, 1, "p7_done");

    // All requesting: strict rotation with one idle cycle between grants
    step(1, 8'hFF, 0, "rot_first");
    for (int i = 0; i < 9; i++) begin
      step(1, 8'hFF, 1, "rot_done");
      step(1, 8'hFF, 0, "rot_grant");
    end
    step(1, 8'hFF, 1, "rot_end");

    // Grant to 3, drop req[3], pending 0 and 3 -> wrap to 0
    step(1, 8'h00, 0, "w_idle");
    step(1, 8'h08, 0, "w_g3");
    chk("w_is_3", {5'd0, gnt_idx}, 8'd3);
    step(1, 8'h01, 0, "w_drop3");
    step(1, 8'h09, 0, "w_g0");
    chk("w_is_0", {5'd0, gnt_idx}, 8'd0);
    step(1, 8'h00, 0, "w_rel");

    // done while idle is ignored
    for (int i = 0; i < 3; i++) step(1, 8'h00, 1, "idle_done");

    // Reset in the middle of a grant to 5
    step(1, 8'h20, 0, "r5_grant");
    step(1, 8'h20, 0, "r5_hold");
    step(0, 8'h20, 0, "r5_reset");
    chk("r5_dropped", gnt, 8'h00);
    step(1, 8'h20, 0, "r5_regrant");
    chk("r5_again", gnt, 8'h20);
    step(1, 8'h00, 0, "r5_rel");
    step(1, 8'h00, 0, "r5_idle");

    // Lone requester 2 held for 100 cycles
    n_to = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 8'h04, 0, "hold2");
      n_to += int'(timeout);
    end
`ifdef ARB_TIMEOUT_EN
    chk("hold2_timeouts", 8'(n_to), 8'd20);
`else
    chk("hold2_timeouts", 8'(n_to), 8'd0);
    chk("hold2_still", gnt, 8'h04);
`endif
    step(1, 8'h00, 0, "hold2_rel");

    // Random traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      rq = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(($urandom_range(0, 39) != 0), rq, ($urandom_range(0, 3) == 0), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
